// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer.
//   state_e              : qualification FSM states
//   DEBOUNCE_27MHZ_10MS  : default qualification length (10 ms at 27 MHz)
package debounce_pkg;

    localparam int unsigned DEBOUNCE_27MHZ_10MS = 270000;

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_HELD         = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_e;

endpackage : debounce_pkg

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous input bit.
//   clk      : destination clock
//   reset_n  : asynchronous active-low reset, loads RST_VAL into every stage
//   d        : asynchronous input
//   q        : synchronized output (last stage)
module bit_sync #(
    parameter int unsigned STAGES  = 2,
    parameter bit          RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift chain: stage 0 samples the raw input, the top stage is the output.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : bit_sync

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronizes a raw bouncing pin, requires
// DEBOUNCE_CYCLES consecutive stable samples before accepting a new level,
// and emits one-cycle press/release strobes alongside the clean level.
//   clk        : system clock
//   reset_n    : asynchronous active-low reset (from the power-on source)
//   button_in  : raw pin, asynchronous, may bounce
//   button_out : debounced level, same polarity as button_in
//   pressed    : one-cycle strobe on acceptance of the pressed level
//   released   : one-cycle strobe on acceptance of the released level
module button_debounce
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_27MHZ_10MS,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button_in,
    output logic button_out,
    output logic pressed,
    output logic released
);

    localparam logic        IDLE_LVL = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync_q;
    state_e           state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             button_out_q, button_out_d;
    logic             pressed_q,    pressed_d;
    logic             released_q,   released_d;

    // Raw pin enters the clock domain only through the synchronizer.
    bit_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (IDLE_LVL)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (button_in),
        .q       (sync_q)
    );

    // Qualification FSM. Entering a WAIT state counts the first agreeing
    // sample as 1, so completion at CNT_MAX means DEBOUNCE_CYCLES samples.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        button_out_d = button_out_q;
        pressed_d    = 1'b0;
        released_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sync_q != IDLE_LVL) begin
                    state_d = S_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            S_PRESS_WAIT: begin
                if (sync_q == IDLE_LVL) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d      = S_HELD;
                    button_out_d = ~IDLE_LVL;
                    pressed_d    = 1'b1;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HELD: begin
                if (sync_q == IDLE_LVL) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            S_RELEASE_WAIT: begin
                if (sync_q != IDLE_LVL) begin
                    state_d = S_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d      = S_IDLE;
                    button_out_d = IDLE_LVL;
                    released_d   = 1'b1;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            button_out_q <= IDLE_LVL;
            pressed_q    <= 1'b0;
            released_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            button_out_q <= button_out_d;
            pressed_q    <= pressed_d;
            released_q   <= released_d;
        end
    end

    assign button_out = button_out_q;
    assign pressed    = pressed_q;
    assign released   = released_q;

endmodule : button_debounce

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=8, SYNC_STAGES=2,
// ACTIVE_LOW=1: acceptance latency from the first sampling edge is 10 cycles.
module tb_button_debounce;
    import debounce_pkg::*;

    logic clk;
    logic reset_n;
    logic button_in;
    logic button_out;
    logic pressed;
    logic released;

    int checks;
    int errors;

    button_debounce #(
        .DEBOUNCE_CYCLES (8),
        .SYNC_STAGES     (2),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .button_in  (button_in),
        .button_out (button_out),
        .pressed    (pressed),
        .released   (released)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle 1 ns past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Run n cycles watching outputs. exp_at is the cycle (1-based) where the
    // single expected strobe and the button_out change occur, -1 for none.
    task automatic watch(input string tag, input int n, input int exp_p,
                         input int exp_r, input int exp_at, input int exp_out);
        int cnt_p;
        int cnt_r;
        int both;
        int first_strobe;
        int first_change;
        logic prev_out;
        cnt_p        = 0;
        cnt_r        = 0;
        both         = 0;
        first_strobe = -1;
        first_change = -1;
        prev_out     = button_out;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (pressed === 1'b1)  cnt_p++;
            if (released === 1'b1) cnt_r++;
            if (pressed === 1'b1 && released === 1'b1) both++;
            if ((pressed === 1'b1 || released === 1'b1) && first_strobe < 0)
                first_strobe = k;
            if (button_out !== prev_out && first_change < 0)
                first_change = k;
            prev_out = button_out;
        end
        chk({tag, "_pressed_cnt"},  cnt_p, exp_p);
        chk({tag, "_released_cnt"}, cnt_r, exp_r);
        chk({tag, "_both_high"},    both, 0);
        chk({tag, "_strobe_cycle"}, first_strobe, exp_at);
        chk({tag, "_out_change"},   first_change, exp_at);
        chk({tag, "_out_end"},      int'(button_out), exp_out);
    endtask

    initial begin
        int bounce_strobes;
        checks    = 0;
        errors    = 0;
        clk       = 1'b0;
        reset_n   = 1'b0;
        button_in = 1'b1;

        // Reset with button idle
        repeat (3) tick();
        chk("rst_out",      int'(button_out), 1);
        chk("rst_pressed",  int'(pressed), 0);
        chk("rst_released", int'(released), 0);
        reset_n = 1'b1;
        watch("idle", 20, 0, 0, -1, 1);

        // Clean press, then clean release
        button_in = 1'b0;
        watch("press", 15, 1, 0, 10, 0);
        button_in = 1'b1;
        watch("release", 15, 0, 1, 10, 1);

        // Bounce: runs of three low / three high for 40 cycles
        bounce_strobes = 0;
        for (int c = 0; c < 40; c++) begin
            button_in = ((c % 6) < 3) ? 1'b0 : 1'b1;
            tick();
            if (pressed === 1'b1 || released === 1'b1) bounce_strobes++;
        end
        chk("bounce_strobes", bounce_strobes, 0);
        chk("bounce_out", int'(button_out), 1);
        button_in = 1'b0;
        watch("bounce_settle", 15, 1, 0, 10, 0);

        // Seven-cycle high glitch while held is rejected
        button_in = 1'b1;
        watch("glitch", 7, 0, 0, -1, 0);
        button_in = 1'b0;
        watch("glitch_tail", 12, 0, 0, -1, 0);
        button_in = 1'b1;
        watch("glitch_release", 15, 0, 1, 10, 1);

        // Async reset in the middle of press qualification
        button_in = 1'b0;
        repeat (7) tick();
        chk("mid_state", int'(dut.state_q), int'(S_PRESS_WAIT));
        chk("mid_cnt",   int'(dut.cnt_q), 5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_out",   int'(button_out), 1);
        chk("async_rst_cnt",   int'(dut.cnt_q), 0);
        chk("async_rst_state", int'(dut.state_q), int'(S_IDLE));
        repeat (2) tick();
        reset_n = 1'b1;
        watch("held_thru_rst", 15, 1, 0, 10, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_button_debounce
